// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer (mode 0) that drives an external sckgen.
// It frames one word per accepted start with chip select, enables sckgen,
// shifts MOSI on sck_fall, samples MISO on sck_rise, and can chain words
// without releasing chip select when cont was set.
module spi_xfer_ctrl #(
  parameter int DATA_W    = 8,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sck_en,
  input  logic              sck_rise,
  input  logic              sck_fall,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  // One down-counter serves both the setup and the hold interval.
  localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BIT_W   = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(CS_HOLD - 1);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [BIT_W-1:0]  bitcnt, bitcnt_nxt, bitcnt_rise;
  logic [DATA_W-1:0] tx_sr, tx_sr_nxt;
  logic [DATA_W-1:0] rx_sr, rx_sr_nxt;
  logic [DATA_W-1:0] rx_data_nxt;
  logic              cont_q, cont_nxt;
  logic              cs_n_nxt, sck_en_nxt, mosi_nxt, busy_nxt, done_nxt;
  logic              rise_ok;

  // Bit that leaves the shifter first, given the configured bit order.
  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  // Drop the bit just sent so the next one sits in the first_bit position.
  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  // Append a received bit so the word reassembles in transmit order.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
    return MSB_FIRST ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
  endfunction

  // Next-state and next-output logic; rise is applied before fall in the same cycle.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bitcnt_nxt  = bitcnt;
    tx_sr_nxt   = tx_sr;
    rx_sr_nxt   = rx_sr;
    rx_data_nxt = rx_data;
    cont_nxt    = cont_q;
    cs_n_nxt    = cs_n;
    sck_en_nxt  = sck_en;
    mosi_nxt    = mosi;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    rise_ok     = sck_rise && (bitcnt < LAST_BIT);
    bitcnt_rise = rise_ok ? bitcnt + 1'b1 : bitcnt;

    case (state)
      IDLE: begin
        if (start) begin
          tx_sr_nxt = tx_data;
          cont_nxt  = cont;
          cs_n_nxt  = 1'b0;
          busy_nxt  = 1'b1;
          mosi_nxt  = first_bit(tx_data);
          cnt_nxt   = SETUP_LOAD;
          state_nxt = SETUP;
        end
      end

      SETUP: begin
        if (cnt == '0) begin
          sck_en_nxt = 1'b1;
          bitcnt_nxt = '0;
          state_nxt  = SHIFT;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      SHIFT: begin
        if (rise_ok) begin
          rx_sr_nxt = shift_in(rx_sr, miso);
        end
        bitcnt_nxt = bitcnt_rise;
        if (sck_fall) begin
          if (bitcnt_rise < LAST_BIT) begin
            tx_sr_nxt = shift_out(tx_sr);
            mosi_nxt  = first_bit(shift_out(tx_sr));
          end else begin
            sck_en_nxt = 1'b0;
            cnt_nxt    = HOLD_LOAD;
            state_nxt  = HOLD;
          end
        end
      end

      HOLD: begin
        if (cnt == '0) begin
          rx_data_nxt = rx_sr;
          done_nxt    = 1'b1;
          if (cont_q && start) begin
            tx_sr_nxt = tx_data;
            cont_nxt  = cont;
            mosi_nxt  = first_bit(tx_data);
            cnt_nxt   = SETUP_LOAD;
            state_nxt = SETUP;
          end else begin
            cs_n_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset releases chip select and discards any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bitcnt  <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_data <= '0;
      cont_q  <= 1'b0;
      cs_n    <= 1'b1;
      sck_en  <= 1'b0;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bitcnt  <= bitcnt_nxt;
      tx_sr   <= tx_sr_nxt;
      rx_sr   <= rx_sr_nxt;
      rx_data <= rx_data_nxt;
      cont_q  <= cont_nxt;
      cs_n    <= cs_n_nxt;
      sck_en  <= sck_en_nxt;
      mosi    <= mosi_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl: an MSB-first instance exercised with
// directed and random words, plus an LSB-first instance for bit-order checks.
// A simple sckgen stand-in produces strobes; a monitor records framing events.
module tb_spi_xfer_ctrl;

  localparam int DATA_W   = 8;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, cont;
  logic [7:0] tx_data;
  logic       busy, done;
  logic [7:0] rx_data;
  logic       sck_en, cs_n, mosi;
  logic       sck_rise = 1'b0;
  logic       sck_fall = 1'b0;
  logic       miso = 1'b0;

  logic       start_l;
  logic       cont_l;
  logic [7:0] tx_data_l;
  logic       busy_l, done_l;
  logic [7:0] rx_data_l;
  logic       sck_en_l, cs_n_l, mosi_l;
  logic       sck_rise_l = 1'b0;
  logic       sck_fall_l = 1'b0;
  logic       miso_l = 1'b0;

  int checks;
  int errors;

  // sckgen stand-in and event monitor state
  int         cyc = 0;
  int         seg_start = 0;
  int         hold_start = 0;
  int         div = 0;
  int         half = 1;
  int         cur_rises = 0;
  int         double_done = 0;
  logic       lvl = 1'b0;
  logic [7:0] cur_mosi = '0;
  bit         loopback = 1'b1;
  logic [7:0] pattern = '0;
  logic       prev_cs_n = 1'b1;
  logic       prev_sck_en = 1'b0;
  logic       prev_done = 1'b0;
  int         setup_q[$];
  int         hold_q[$];
  int         rises_q[$];
  logic [7:0] mosi_q[$];
  logic [7:0] done_q[$];

  int         l_rises = 0;
  int         l_last_rises = 0;
  int         l_dones = 0;
  logic       lvl_l = 1'b0;
  logic       prev_sck_en_l = 1'b0;
  logic [7:0] l_word = '0;
  logic [7:0] l_last_word = '0;

  logic [7:0] t, a, b;

  spi_xfer_ctrl #(.DATA_W(DATA_W), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .tx_data(tx_data),
    .busy(busy), .done(done), .rx_data(rx_data), .sck_en(sck_en),
    .sck_rise(sck_rise), .sck_fall(sck_fall), .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  spi_xfer_ctrl #(.DATA_W(DATA_W), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .start(start_l), .cont(cont_l), .tx_data(tx_data_l),
    .busy(busy_l), .done(done_l), .rx_data(rx_data_l), .sck_en(sck_en_l),
    .sck_rise(sck_rise_l), .sck_fall(sck_fall_l), .cs_n(cs_n_l), .mosi(mosi_l), .miso(miso_l)
  );

  always #5 clk = ~clk;

  // Strobe generator for the MSB-first instance plus recording of framing intervals,
  // bits seen on MOSI at each rise, and every done pulse.
  always @(negedge clk) begin
    cyc++;
    sck_rise = 1'b0;
    sck_fall = 1'b0;
    if (rst) begin
      div = 0; lvl = 1'b0; cur_rises = 0; cur_mosi = '0;
      prev_cs_n = 1'b1; prev_sck_en = 1'b0; prev_done = 1'b0;
    end else begin
      if (sck_en) begin
        div++;
        if (div >= half) begin
          div = 0;
          if (!lvl) begin
            lvl = 1'b1;
            sck_rise = 1'b1;
            cur_mosi = {cur_mosi[6:0], mosi};
            miso = loopback ? mosi : ((cur_rises < 8) ? pattern[7 - cur_rises] : 1'b0);
            cur_rises++;
          end else begin
            lvl = 1'b0;
            sck_fall = 1'b1;
          end
        end
      end else begin
        div = 0;
        lvl = 1'b0;
      end
      if (prev_cs_n && !cs_n) seg_start = cyc;
      if (done) begin
        done_q.push_back(rx_data);
        seg_start = cyc;
        if (prev_done) double_done++;
      end
      if (!prev_sck_en && sck_en) setup_q.push_back(cyc - seg_start);
      if (prev_sck_en && !sck_en) begin
        hold_start = cyc;
        rises_q.push_back(cur_rises);
        mosi_q.push_back(cur_mosi);
        cur_rises = 0;
        cur_mosi = '0;
      end
      if (!prev_cs_n && cs_n) hold_q.push_back(cyc - hold_start);
      prev_cs_n = cs_n;
      prev_sck_en = sck_en;
      prev_done = done;
    end
  end

  // Strobe generator and bit recorder for the LSB-first instance, looped back.
  always @(negedge clk) begin
    sck_rise_l = 1'b0;
    sck_fall_l = 1'b0;
    if (rst) begin
      lvl_l = 1'b0; l_rises = 0; l_word = '0; prev_sck_en_l = 1'b0;
    end else begin
      if (sck_en_l) begin
        if (!lvl_l) begin
          lvl_l = 1'b1;
          sck_rise_l = 1'b1;
          miso_l = mosi_l;
          if (l_rises < 8) l_word[l_rises] = mosi_l;
          l_rises++;
        end else begin
          lvl_l = 1'b0;
          sck_fall_l = 1'b1;
        end
      end else begin
        lvl_l = 1'b0;
      end
      if (prev_sck_en_l && !sck_en_l) begin
        l_last_rises = l_rises;
        l_last_word = l_word;
        l_rises = 0;
        l_word = '0;
      end
      if (done_l) l_dones++;
      prev_sck_en_l = sck_en_l;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int n);
    int guard;
    guard = 0;
    while (done_q.size() < n && guard < 2000) begin
      step();
      guard++;
    end
    checkOutput("done_seen", done_q.size() >= n, 1);
  endtask

  // Compare one finished word against what the serial protocol should have produced.
  task automatic check_word(input logic [7:0] tx, input logic [7:0] exp_rx);
    checkOutput("setup_len", setup_q.size() ? setup_q.pop_front() : -1, CS_SETUP);
    checkOutput("rise_count", rises_q.size() ? rises_q.pop_front() : -1, DATA_W);
    checkOutput("mosi_word", mosi_q.size() ? 32'(mosi_q.pop_front()) : 32'hDEAD, 32'(tx));
    checkOutput("rx_data", done_q.size() ? 32'(done_q.pop_front()) : 32'hDEAD, 32'(exp_rx));
  endtask

  task automatic check_idle_after();
    repeat (CS_SETUP + 6) step();
    checkOutput("extra_done", done_q.size(), 0);
    checkOutput("hold_cnt", hold_q.size(), 1);
    checkOutput("hold_len", hold_q.size() ? hold_q.pop_front() : -1, CS_HOLD);
    checkOutput("idle_cs_n", cs_n, 1);
    checkOutput("idle_busy", busy, 0);
  endtask

  task automatic applyStimulus(input logic [7:0] tx, input logic [7:0] exp_rx, input bit poke);
    int guard;
    start = 1'b1; tx_data = tx; cont = 1'b0;
    step();
    start = 1'b0; tx_data = ~tx;
    checkOutput("busy_on", busy, 1);
    checkOutput("cs_low", cs_n, 0);
    if (poke) begin
      guard = 0;
      while (cur_rises < 3 && guard < 500) begin
        step();
        guard++;
      end
      checkOutput("poke_reach", cur_rises >= 3, 1);
      start = 1'b1; tx_data = 8'h00; cont = 1'b1;
      step();
      start = 1'b0; cont = 1'b0; tx_data = ~tx;
    end
    wait_done(1);
    check_word(tx, exp_rx);
    check_idle_after();
  endtask

  task automatic run_chain(input logic [7:0] w0, input logic [7:0] w1, input logic c2);
    int guard;
    loopback = 1'b1;
    start = 1'b1; tx_data = w0; cont = 1'b1;
    step();
    start = 1'b0; cont = 1'b0; tx_data = ~w0;
    guard = 0;
    while (rises_q.size() < 1 && guard < 1000) begin
      step();
      guard++;
    end
    checkOutput("chain_first_end", rises_q.size(), 1);
    start = 1'b1; tx_data = w1; cont = c2;
    wait_done(1);
    start = 1'b0; cont = 1'b0; tx_data = ~w1;
    check_word(w0, w0);
    checkOutput("chain_cs_n", cs_n, 0);
    checkOutput("chain_busy", busy, 1);
    wait_done(1);
    check_word(w1, w1);
    check_idle_after();
  endtask

  initial begin
    int guard;
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; cont = 1'b0; tx_data = '0;
    start_l = 1'b0; cont_l = 1'b0; tx_data_l = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cs_n", cs_n, 1);
    checkOutput("rst_sck_en", sck_en, 0);
    checkOutput("rst_mosi", mosi, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_rx_data", rx_data, 0);
    rst = 1'b0;
    step();

    // loopback A5, slow clock
    loopback = 1'b1; half = 2;
    applyStimulus(8'hA5, 8'hA5, 1'b0);
    // miso tied high, all-zero word
    loopback = 1'b0; pattern = 8'hFF; half = 1;
    applyStimulus(8'h00, 8'hFF, 1'b0);
    // start pulsed mid-word is ignored
    loopback = 1'b1; half = 2;
    applyStimulus(8'h3C, 8'h3C, 1'b1);
    // chained words under one chip select
    half = 1;
    run_chain(8'h3C, 8'hC3, 1'b0);

    // reset in the middle of a word
    loopback = 1'b0; pattern = 8'h5A; half = 2;
    start = 1'b1; tx_data = 8'hFF;
    step();
    start = 1'b0;
    guard = 0;
    while (cur_rises < 4 && guard < 500) begin
      step();
      guard++;
    end
    checkOutput("rst_mid_reach", cur_rises >= 4, 1);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_cs_n", cs_n, 1);
    checkOutput("rst_mid_sck_en", sck_en, 0);
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_rx", rx_data, 0);
    @(negedge clk);
    step();
    rst = 1'b0;
    setup_q.delete(); hold_q.delete(); rises_q.delete(); mosi_q.delete(); done_q.delete();
    step();
    loopback = 1'b1;
    applyStimulus(8'h81, 8'h81, 1'b0);

    // LSB-first instance: 0x01 sends a one on the first bit only
    start_l = 1'b1; tx_data_l = 8'h01;
    step();
    start_l = 1'b0; tx_data_l = 8'hFE;
    guard = 0;
    while (l_dones < 1 && guard < 500) begin
      step();
      guard++;
    end
    repeat (6) step();
    checkOutput("lsb_dones", l_dones, 1);
    checkOutput("lsb_rises", l_last_rises, DATA_W);
    checkOutput("lsb_mosi_word", l_last_word, 8'h01);
    checkOutput("lsb_rx_data", rx_data_l, 8'h01);
    checkOutput("lsb_idle", {cs_n_l, busy_l}, 2'b10);

    // random single words: loopback or random MISO pattern
    for (int i = 0; i < 20; i++) begin
      half = $urandom_range(1, 3);
      loopback = bit'($urandom_range(0, 1));
      pattern = 8'($urandom);
      t = 8'($urandom);
      applyStimulus(t, loopback ? t : pattern, 1'b0);
    end
    // random chained pairs
    for (int i = 0; i < 4; i++) begin
      half = $urandom_range(1, 3);
      a = 8'($urandom);
      b = 8'($urandom);
      run_chain(a, b, 1'($urandom_range(0, 1)));
    end

    checkOutput("done_one_cycle", double_done, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
